// File: rtl/snn_clk_div_pkg.sv
// Shared types and default sizing for the SNN clock-divider tick generator.
package snn_clk_div_pkg;

   localparam int unsigned DivWDefault        = 8;
   localparam int unsigned CntWDefault        = 16;
   localparam int unsigned SyncStagesDefault  = 2;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StRun  = 2'd2
   } state_e;

endpackage

// File: rtl/sync_ff.sv
// Flop-chain synchroniser for slow, level-type signals crossing into the clk domain.
module sync_ff #(
   parameter int unsigned STAGES = 2,
   parameter int unsigned WIDTH  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [STAGES-1:0][WIDTH-1:0] chain_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/snn_clk_div_tick_gen.sv
// Periodic SNN update-enable generator driven by the SPI clock-divider configuration.
module snn_clk_div_tick_gen
   import snn_clk_div_pkg::*;
#(
   parameter int unsigned DIV_W       = DivWDefault,
   parameter int unsigned CNT_W       = CntWDefault,
   parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_div_ready_i,
   input  logic [DIV_W-1:0] div_value_i,
   input  logic             freeze_i,
   output logic             tick_o,
   output logic             div_active_o,
   output logic             cfg_load_o,
   output logic [CNT_W-1:0] tick_count_o
);

   logic             rdy_s;
   logic             rdy_q;
   logic             rdy_rise;
   state_e           state_q, state_d;
   logic [DIV_W-1:0] shadow_q, shadow_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] tcnt_q, tcnt_d;

   sync_ff #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (1)
   ) u_rdy_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (clk_div_ready_i),
      .q_o   (rdy_s)
   );

   assign rdy_rise = rdy_s & ~rdy_q;

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      tcnt_d   = tcnt_q;
      unique case (state_q)
         StIdle: begin
            if (rdy_rise) begin
               state_d  = StLoad;
               shadow_d = div_value_i;
            end
         end
         StLoad: begin
            if (!rdy_s) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               state_d = StRun;
               cnt_d   = shadow_q;
               tcnt_d  = '0;
            end
         end
         StRun: begin
            // Losing ready wins over freeze; tick_count is kept for software readback.
            if (!rdy_s) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (!freeze_i) begin
               if (cnt_q == '0) begin
                  cnt_d  = shadow_q;
                  tcnt_d = tcnt_q + CNT_W'(1);
               end else begin
                  cnt_d = cnt_q - DIV_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         rdy_q    <= 1'b0;
         shadow_q <= '0;
         cnt_q    <= '0;
         tcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         rdy_q    <= rdy_s;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         tcnt_q   <= tcnt_d;
      end
   end

   assign tick_o       = (state_q == StRun) & ~freeze_i & (cnt_q == '0);
   assign div_active_o = (state_q == StRun);
   assign cfg_load_o   = (state_q == StLoad);
   assign tick_count_o = tcnt_q;

endmodule

// File: tb/tb_snn_clk_div_tick_gen.sv
// Scoreboard bench: expected tick cycles/counts queued by stimulus, checked by a tick monitor.
module tb_snn_clk_div_tick_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clk_div_ready;
   logic [7:0]  div_value;
   logic        freeze;
   logic        tick, div_active, cfg_load;
   logic [15:0] tick_count;
   logic        tick_w, div_active_w, cfg_load_w;
   logic [3:0]  tick_count_w;

   int cyc = 0;
   int compared = 0;
   int mismatched = 0;

   typedef struct {
      int cyc;
      int cnt;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   snn_clk_div_tick_gen u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .clk_div_ready_i (clk_div_ready),
      .div_value_i     (div_value),
      .freeze_i        (freeze),
      .tick_o          (tick),
      .div_active_o    (div_active),
      .cfg_load_o      (cfg_load),
      .tick_count_o    (tick_count)
   );

   snn_clk_div_tick_gen #(
      .CNT_W (4)
   ) u_dut_w (
      .clk             (clk),
      .rst_n           (rst_n),
      .clk_div_ready_i (clk_div_ready),
      .div_value_i     (div_value),
      .freeze_i        (freeze),
      .tick_o          (tick_w),
      .div_active_o    (div_active_w),
      .cfg_load_o      (cfg_load_w),
      .tick_count_o    (tick_count_w)
   );

   task automatic chk(input string name, input longint got, input longint want);
      compared++;
      if (got != want) begin
         mismatched++;
         $display("FAIL %s at cyc %0d: got %0d, required %0d", name, cyc, got, want);
      end
   endtask

   // Monitor: every tick must match the head of the expected queue.
   always @(negedge clk) begin
      exp_t e;
      if (tick || tick_w) chk("tick_vs_wrap_build", tick_w, tick);
      if (tick) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_tick", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("tick_cycle", cyc, e.cyc);
            chk("tick_count_at_tick", tick_count, e.cnt);
            chk("tick_count_w_at_tick", tick_count_w, e.cnt % 16);
         end
      end
   end

   task automatic wait_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) wait_neg();
   endtask

   task automatic push(input int t, input int k);
      exp_t e;
      e.cyc = t;
      e.cnt = k;
      exp_q.push_back(e);
   endtask

   // Raise ready with divider d, drop it 'hold' cycles later; checks LOAD pulse and exit.
   task automatic run_seg(input int d, input int hold);
      int n, m, k, counted;
      n = cyc;
      m = n + hold;
      k = 0;
      counted = 0;
      for (int t = n + 4 + d; t <= m + 2; t += d + 1) begin
         push(t, k);
         if (t <= m + 1) counted++;
         k++;
      end
      div_value = 8'(d);
      clk_div_ready = 1'b1;
      wait_until(n + 2);
      chk("cfg_load_before", cfg_load, 0);
      wait_until(n + 3);
      chk("cfg_load_pulse", cfg_load, 1);
      chk("div_active_in_load", div_active, 0);
      wait_until(n + 4);
      chk("cfg_load_after", cfg_load, 0);
      chk("div_active_run", div_active, 1);
      wait_until(m);
      clk_div_ready = 1'b0;
      wait_until(m + 2);
      chk("div_active_drain", div_active, 1);
      wait_until(m + 3);
      chk("div_active_idle", div_active, 0);
      chk("tick_idle", tick, 0);
      chk("tick_count_held", tick_count, counted);
      chk("tick_count_w_held", tick_count_w, counted % 16);
      repeat (2) wait_neg();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   initial begin
      int n;
      rst_n = 1'b0;
      clk_div_ready = 1'b0;
      div_value = 8'd0;
      freeze = 1'b0;
      repeat (2) wait_neg();
      chk("rst_tick", tick, 0);
      chk("rst_div_active", div_active, 0);
      chk("rst_cfg_load", cfg_load, 0);
      chk("rst_tick_count", tick_count, 0);
      chk("rst_tick_count_w", tick_count_w, 0);
      rst_n = 1'b1;
      repeat (3) wait_neg();
      chk("idle_div_active", div_active, 0);

      run_seg(3, 22);   // five ticks, period 4
      run_seg(0, 30);   // tick every cycle; 4-bit build wraps 15->0
      run_seg(2, 20);
      run_seg(7, 30);   // reload: new period, tick_count restarts

      // Freeze for 10 cycles mid-period delays the next tick by exactly 10.
      n = cyc;
      push(n + 8, 0);
      push(n + 23, 1);
      push(n + 28, 2);
      push(n + 33, 3);
      div_value = 8'd4;
      clk_div_ready = 1'b1;
      wait_until(n + 10);
      freeze = 1'b1;
      wait_until(n + 20);
      freeze = 1'b0;
      wait_until(n + 36);
      freeze = 1'b1;
      clk_div_ready = 1'b0;
      wait_until(n + 38);
      chk("frz_drop_active", div_active, 1);
      wait_until(n + 39);
      chk("frz_drop_idle", div_active, 0);
      chk("frz_tick_count", tick_count, 4);
      freeze = 1'b0;
      repeat (2) wait_neg();

      // Mid-run divider change is ignored; async reset clears everything at once.
      n = cyc;
      push(n + 9, 0);
      push(n + 15, 1);
      push(n + 21, 2);
      div_value = 8'd5;
      clk_div_ready = 1'b1;
      wait_until(n + 12);
      div_value = 8'd9;
      wait_until(n + 22);
      rst_n = 1'b0;
      clk_div_ready = 1'b0;
      #1;
      chk("arst_tick", tick, 0);
      chk("arst_div_active", div_active, 0);
      chk("arst_cfg_load", cfg_load, 0);
      chk("arst_tick_count", tick_count, 0);
      chk("arst_tick_count_w", tick_count_w, 0);
      repeat (3) wait_neg();
      rst_n = 1'b1;
      repeat (8) wait_neg();
      chk("post_rst_idle", div_active, 0);
      run_seg(1, 12);

      repeat (5) wait_neg();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
